// File: rtl/mdu_unit_pkg.sv
// Shared opcode and state types for the multiply/divide unit.
// Opcodes are also consumed by the controller and hazard unit.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    MduNop   = 4'd0,
    MduMult  = 4'd1,
    MduMultu = 4'd2,
    MduDiv   = 4'd3,
    MduDivu  = 4'd4,
    MduMfhi  = 4'd5,
    MduMflo  = 4'd6,
    MduMthi  = 4'd7,
    MduMtlo  = 4'd8,
    MduMadd  = 4'd9,
    MduMaddu = 4'd10,
    MduMsub  = 4'd11,
    MduMsubu = 4'd12
  } mdu_op_e;

  typedef enum logic {
    StIdle,
    StRun
  } mdu_state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MduDiv) || (op == MduDivu);
  endfunction

endpackage

// File: rtl/mdu_unit_fsm.sv
// Occupancy FSM for the MDU: IDLE/RUN state, latency counter and busy flag.
// last_o marks the final RUN edge, on which the datapath commits HI/LO.
module mdu_unit_fsm
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MultCyc = 5,
  parameter int unsigned DivCyc  = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic launch_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic last_o
);

  localparam int unsigned MaxCyc = (MultCyc > DivCyc) ? MultCyc : DivCyc;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch_i) begin
          state_d = StRun;
          cnt_d   = is_div_i ? CntW'(DivCyc) : CntW'(MultCyc);
        end
      end
      StRun: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          last_o  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == StRun);

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency mult/div plus mfhi/mflo/mthi/mtlo.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu accumulate ops.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] MDUSrcA_E,
  input  logic [31:0] MDUSrcB_E,
  input  logic [3:0]  MDUOp_E,
  input  logic        Start_E,
  output logic        Busy_E,
  output logic [31:0] MDUResult_E,
  output logic [31:0] HI_E,
  output logic [31:0] LO_E
);

  logic [31:0] hi_q, lo_q;
  logic [63:0] temp_q, temp_d;
  logic        wr_q, wr_d;
  logic        is_launch, launch, last;

  logic [31:0] a, b, b_div;
  logic [63:0] prod_s, prod_u;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic        b_zero, div_ovf;

  assign a = MDUSrcA_E;
  assign b = MDUSrcB_E;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Divisor forced to 1 when zero so the dividers never produce X; result is discarded anyway.
  assign b_zero  = (b == 32'd0);
  assign b_div   = b_zero ? 32'd1 : b;
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign q_s     = div_ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b_div));
  assign r_s     = div_ovf ? 32'd0 : 32'($signed(a) % $signed(b_div));
  assign q_u     = a / b_div;
  assign r_u     = a % b_div;

  always_comb begin
    is_launch = 1'b0;
    temp_d    = temp_q;
    wr_d      = wr_q;
    case (MDUOp_E)
      MduMult:  begin is_launch = 1'b1; temp_d = prod_s;       wr_d = 1'b1;    end
      MduMultu: begin is_launch = 1'b1; temp_d = prod_u;       wr_d = 1'b1;    end
      MduDiv:   begin is_launch = 1'b1; temp_d = {r_s, q_s};   wr_d = !b_zero; end
      MduDivu:  begin is_launch = 1'b1; temp_d = {r_u, q_u};   wr_d = !b_zero; end
`ifdef MDU_MADD_EN
      MduMadd:  begin is_launch = 1'b1; temp_d = {hi_q, lo_q} + prod_s; wr_d = 1'b1; end
      MduMaddu: begin is_launch = 1'b1; temp_d = {hi_q, lo_q} + prod_u; wr_d = 1'b1; end
      MduMsub:  begin is_launch = 1'b1; temp_d = {hi_q, lo_q} - prod_s; wr_d = 1'b1; end
      MduMsubu: begin is_launch = 1'b1; temp_d = {hi_q, lo_q} - prod_u; wr_d = 1'b1; end
`endif
      default:  ;
    endcase
  end

  assign launch = Start_E && !Busy_E && is_launch;

  mdu_unit_fsm #(
    .MultCyc (MULT_CYC),
    .DivCyc  (DIV_CYC)
  ) u_fsm (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .launch_i (launch),
    .is_div_i (is_div_op(MDUOp_E)),
    .busy_o   (Busy_E),
    .last_o   (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      temp_q <= '0;
      wr_q   <= 1'b0;
    end else if (launch) begin
      temp_q <= temp_d;
      wr_q   <= wr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (last) begin
      if (wr_q) begin
        hi_q <= temp_q[63:32];
        lo_q <= temp_q[31:0];
      end
    end else if (!Busy_E && !Start_E) begin
      if (MDUOp_E == MduMthi) hi_q <= a;
      if (MDUOp_E == MduMtlo) lo_q <= a;
    end
  end

  always_comb begin
    MDUResult_E = '0;
    if (MDUOp_E == MduMfhi) MDUResult_E = hi_q;
    if (MDUOp_E == MduMflo) MDUResult_E = lo_q;
  end

  assign HI_E = hi_q;
  assign LO_E = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: latency, arithmetic, HI/LO moves and reset.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  op = 4'd0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] res, hi, lo;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  mdu_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .MDUSrcA_E   (a),
    .MDUSrcB_E   (b),
    .MDUOp_E     (op),
    .Start_E     (start),
    .Busy_E      (busy),
    .MDUResult_E (res),
    .HI_E        (hi),
    .LO_E        (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = MduNop;
  endtask

  // Counts busy cycles starting at the first negedge after launch; bounded.
  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] x);
    @(negedge clk);
    op = o; a = x;
    @(negedge clk);
    op = MduNop;
  endtask

  task automatic rd(input string tag, input logic [3:0] o, input logic [31:0] exp);
    @(negedge clk);
    op = o;
    #1 check(tag, res, exp);
    op = MduNop;
  endtask

  initial begin
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_res", res, 32'd0);
    #11 reset_n = 1'b1;

    // mult -3 * 5
    launch(MduMult, 32'hFFFF_FFFD, 32'd5);
    wait_busy(n);
    check("mult_busy", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    rd("mfhi", MduMfhi, 32'hFFFF_FFFF);
    rd("mflo", MduMflo, 32'hFFFF_FFF1);

    launch(MduMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_busy(n);
    check("multu_busy", n, 32'd5);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    launch(MduDivu, 32'd7, 32'd2);
    wait_busy(n);
    check("divu_busy", n, 32'd10);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    launch(MduDiv, 32'hFFFF_FFF9, 32'd2);
    wait_busy(n);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    launch(MduDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // divide by zero keeps HI/LO
    mt(MduMthi, 32'h1234);
    mt(MduMtlo, 32'h5678);
    check("mthi", hi, 32'h1234);
    check("mtlo", lo, 32'h5678);
    launch(MduDiv, 32'd5, 32'd0);
    wait_busy(n);
    check("div0_busy", n, 32'd10);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'h5678);

    // Start of multu and an mthi while a divu runs must both be ignored
    launch(MduDivu, 32'd100, 32'd7);
    n = 0;
    while (busy && n < 64) begin
      n++;
      if (n == 2) begin
        op = MduMultu; a = 32'd3; b = 32'd3; start = 1'b1;
      end else if (n == 3) begin
        start = 1'b0; op = MduMthi; a = 32'hDEAD;
      end else begin
        start = 1'b0; op = MduNop;
      end
      @(negedge clk);
    end
    op = MduNop;
    check("ovl_busy", n, 32'd10);
    check("ovl_lo", lo, 32'd14);
    check("ovl_hi", hi, 32'd2);
    @(negedge clk);
    check("ovl_nobusy", {31'b0, busy}, 32'd0);
    check("ovl_lo2", lo, 32'd14);

    // reset during the third busy cycle of a mult
    launch(MduMult, 32'd6, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_hi", hi, 32'd0);
    check("mrst_lo", lo, 32'd0);
    #10 reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mrst_hi_late", hi, 32'd0);
    check("mrst_lo_late", lo, 32'd0);
    check("mrst_busy_late", {31'b0, busy}, 32'd0);

    // accumulate op: active only when MDU_MADD_EN is defined
    mt(MduMtlo, 32'hFFFF_FFFF);
    launch(MduMaddu, 32'd1, 32'd1);
    wait_busy(n);
`ifdef MDU_MADD_EN
    check("maddu_busy", n, 32'd5);
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
`else
    check("maddu_busy", n, 32'd0);
    check("maddu_hi", hi, 32'd0);
    check("maddu_lo", lo, 32'hFFFF_FFFF);
`endif
    rd("nop_res", MduNop, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
